axis_to_axi_burst_writer: RTL and testbench
===========================================

Name: axis_to_axi_burst_writer

Overview:
- AXI4 write master that feeds the team's AXI4 RAM slave.
- Consumes a word stream (AXI-Stream style: tdata, tvalid, tready) and writes it to a contiguous word-aligned region as INCR bursts.
- Each burst is bounded by MAX_BURST_LEN and by 4 KB page boundaries.
- A software-style start/busy/done/error interface controls each transfer. Used for bulk preload of RAM contents and test-pattern fill.

Parameters:
- DATA_WIDTH, 32: AXI and stream data width, bits.
- ADDR_WIDTH, 16: AXI address width, bits.
- STRB_WIDTH, DATA_WIDTH/8: bytes per word. Must be a power of two.
- ID_WIDTH, 8: AXI ID width.
- AXI_ID, 0: constant value driven on m_axi_awid.
- MAX_BURST_LEN, 16: maximum beats per burst. Legal range 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  one-cycle request; sampled only in IDLE.
- cfg_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits are ignored (forced 0).
- cfg_len  in  16  number of words to write; 0 = no-op.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse when the transfer completes.
- error  out  1  sticky until next accepted start; set if any bresp != 2'b00.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- m_axi_awid  out  ID_WIDTH  = AXI_ID.
- m_axi_awaddr  out  ADDR_WIDTH  burst start address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  = log2(STRB_WIDTH).
- m_axi_awburst  out  2  = 2'b01 (INCR).
- m_axi_awlock  out  1  = 0.
- m_axi_awcache  out  4  = 4'b0011.
- m_axi_awprot  out  3  = 3'b000.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  DATA_WIDTH  = s_axis_tdata.
- m_axi_wstrb  out  STRB_WIDTH  all ones.
- m_axi_wlast  out  1  last beat of the current burst.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bid  in  ID_WIDTH  ignored.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.

Behaviour:
- Reset values: busy=0, done=0, error=0, awvalid=0, wvalid=0, tready=0, bready=0; state=IDLE; internal address, count and beat registers cleared.
- Reset asserted mid-operation aborts the transfer immediately: no done pulse; outstanding AXI transactions are abandoned. A system-level reset of the slave is assumed to accompany it.
- States: IDLE, ADDR, DATA, RESP, FIN.
- IDLE:
  - On cfg_start, latch addr_reg = cfg_addr with low bits zeroed and rem_reg = cfg_len, and clear error.
  - If cfg_len == 0, go to FIN.
  - Otherwise compute burst_len and go to ADDR.
  - cfg_start outside IDLE is ignored.
- burst_len (registered on entry to ADDR) = min(rem_reg, MAX_BURST_LEN, (4096 - addr_reg[11:0]) / STRB_WIDTH).
  - Use a 13-bit intermediate; result is always >= 1.
  - When ADDR_WIDTH < 12, the page term is computed on the available bits and never limits the burst.
- ADDR: awvalid=1 holding awaddr=addr_reg and awlen=burst_len-1. These values are stable while awvalid is high. On awready, go to DATA with beat_cnt=0.
- DATA:
  - wvalid = s_axis_tvalid; s_axis_tready = m_axi_wready. Both are combinational, qualified by state==DATA, with zero added latency.
  - wlast = (beat_cnt == burst_len-1).
  - A beat transfers when tvalid && wready; beat_cnt increments on each beat.
  - On the last beat, go to RESP.
  - tready is low in every other state, so no stream data is consumed outside DATA.
- RESP:
  - bready=1. On bvalid, error |= (bresp != 0).
  - Update rem_reg -= burst_len and addr_reg += burst_len*STRB_WIDTH; the address wraps modulo 2^ADDR_WIDTH.
  - If the new rem_reg == 0, go to FIN; otherwise go to ADDR (next cycle, recomputing burst_len).
- FIN: done=1 for exactly one cycle, busy=0 that cycle, go to IDLE. A new start is accepted from the following cycle.
- Only one burst is outstanding at a time; AW is never issued before the previous B is received.
- Stream backpressure, wready stalls, and bvalid delays of any length are tolerated without data loss or duplication.
- Ordering: W beats follow AW acceptance. The block never asserts wvalid before its AW handshake.

Test Plan:
- Start addr=0x0000, len=5, stream 0x11..0x15 continuous, slave always ready -> one AW with awaddr=0x0000, awlen=4; 5 W beats, wlast on 0x15; done pulses once; RAM words 0..4 read back 0x11..0x15; error=0.
- Start addr=0x0100, len=40, MAX_BURST_LEN=16 -> three AWs: (0x0100, awlen=15), (0x0140, awlen=15), (0x0180, awlen=7); 40 beats total; done after the third B.
- Start addr=0x0FF0, len=8 -> 4 KB split: AW(0x0FF0, awlen=3) then AW(0x1000, awlen=3).
- Random tvalid gaps (50%), random wready/awready/bvalid delays 0..5 cycles, len=33 -> no lost or duplicated words; every awlen/wlast consistent; busy high throughout.
- len=0 start -> no AXI activity; done pulses 2 cycles after start; busy high 1 cycle. Slave returns bresp=2'b10 on the second burst of len=20 -> transfer completes, done pulses, error=1 until the next start clears it.
- Reset asserted in DATA after 3 beats -> next cycle awvalid/wvalid/tready/busy=0, no done pulse; a subsequent start with len=4 completes normally.

Source files
------------

// File: rtl/axis_to_axi_burst_writer.sv
// Stream-to-AXI4 write master: packs a word stream into INCR bursts bounded by
// MAX_BURST_LEN and 4 KB pages, one burst outstanding at a time.
module axis_to_axi_burst_writer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AXI_ID        = 0,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [15:0]           cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);
    localparam int LSB = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << LSB) - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           rem_q, rem_d;
    logic [8:0]            burst_len_q, burst_len_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  last_beat;
    logic                  unused_bid;

    // Beats for the next burst: remaining words, capped by the burst limit and
    // by the words left before the next 4 KB page boundary.
    function automatic logic [8:0] calc_burst(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [15:0] rem);
        logic [11:0] off;
        logic [12:0] page;
        logic [16:0] len;
        off  = (ADDR_WIDTH >= 12) ? 12'(addr) : 12'd0;
        page = 13'd4096 - {1'b0, off};
        len  = {1'b0, rem};
        if (len > 17'(MAX_BURST_LEN)) len = 17'(MAX_BURST_LEN);
        if (len > 17'(page >> LSB))   len = 17'(page >> LSB);
        return 9'(len);
    endfunction

    assign last_beat = (beat_cnt_q == burst_len_q - 9'd1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        burst_len_d = burst_len_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    addr_d  = cfg_addr & ADDR_MASK;
                    rem_d   = cfg_len;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    if (cfg_len == 16'd0) begin
                        state_d = S_FIN;
                    end else begin
                        burst_len_d = calc_burst(cfg_addr & ADDR_MASK, cfg_len);
                        state_d     = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (m_axi_awready) begin
                    beat_cnt_d = 9'd0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (s_axis_tvalid && m_axi_wready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (last_beat) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    error_d = error_q | (m_axi_bresp != 2'b00);
                    rem_d   = rem_q - 16'(burst_len_q);
                    addr_d  = addr_q + ADDR_WIDTH'(32'(burst_len_q) << LSB);
                    if (rem_d == 16'd0) begin
                        state_d = S_FIN;
                    end else begin
                        burst_len_d = calc_burst(addr_d, rem_d);
                        state_d     = S_ADDR;
                    end
                end
            end
            S_FIN: begin
                // done is registered, so it pulses in the cycle after FIN with busy low
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            burst_len_q <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            burst_len_q <= burst_len_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(burst_len_q - 9'd1);
    assign m_axi_awsize  = 3'(LSB);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == S_ADDR);

    // Stream and W channel are wired straight through while in DATA
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == S_DATA) && s_axis_tvalid;
    assign s_axis_tready = (state_q == S_DATA) && m_axi_wready;
    assign m_axi_wlast   = (state_q == S_DATA) && last_beat;
    assign m_axi_bready  = (state_q == S_RESP);

    assign unused_bid = ^m_axi_bid;
endmodule

// File: tb/tb_axis_to_axi_burst_writer.sv
// Bench for axis_to_axi_burst_writer: stream source, randomizable AXI slave and
// a scoreboard of expected AW requests and W data.
module tb_axis_to_axi_burst_writer;
    localparam int MBL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_addr = '0;
    logic [15:0] cfg_len = '0;
    logic        busy, done, error;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axi_awid;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [7:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    always #5 clk = ~clk;

    axis_to_axi_burst_writer dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
        .busy(busy), .done(done), .error(error),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [31:0] src_q[$];
    logic [31:0] exp_w[$];
    logic [15:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    logic [31:0] mem[0:16383];

    bit rnd_en = 0;
    int err_burst = -1;
    int sst = 0;
    int s_len = 0, s_beats = 0, s_burst_idx = 0;
    logic [15:0] s_addr = '0;
    int aw_cnt = 0, done_cnt = 0, beat_total = 0, order_bad = 0;
    bit aw_hs = 0, w_hs = 0, wl_hs = 0, b_hs = 0;

    // Monitor: values are stable at negedge, so a valid&ready seen here
    // is the handshake that completes on the next rising edge.
    always @(negedge clk) begin
        aw_hs = m_axi_awvalid && m_axi_awready;
        w_hs  = m_axi_wvalid && m_axi_wready;
        wl_hs = w_hs && m_axi_wlast;
        b_hs  = m_axi_bvalid && m_axi_bready;
        if (done) done_cnt++;
        if (!rst) begin
            if (m_axi_wvalid && sst != 1) order_bad++;
            if (aw_hs) begin
                aw_cnt++;
                if (exp_aw_addr.size() == 0) begin
                    check_eq("aw unexpected", 64'(m_axi_awaddr), 64'hFFFF_FFFF);
                end else begin
                    check_eq("awaddr", 64'(m_axi_awaddr), 64'(exp_aw_addr.pop_front()));
                    check_eq("awlen", 64'(m_axi_awlen), 64'(exp_aw_len.pop_front()));
                end
                check_eq("aw attrs", 64'({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                                          m_axi_awcache, m_axi_awprot, m_axi_wstrb}),
                         64'({8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF}));
                s_len   = int'(m_axi_awlen);
                s_beats = 0;
                s_addr  = m_axi_awaddr;
            end
            if (w_hs) begin
                check_eq("wlast", 64'(m_axi_wlast), 64'(s_beats == s_len));
                if (exp_w.size() == 0) check_eq("w unexpected", 64'(m_axi_wdata), 64'hFFFF_FFFF_FFFF);
                else check_eq("wdata", 64'(m_axi_wdata), 64'(exp_w.pop_front()));
                mem[((int'(s_addr) >> 2) + s_beats) % 16384] = m_axi_wdata;
                s_beats++;
                beat_total++;
            end
        end
    end

    // Slave and stream source, driven just after the rising edge
    always @(posedge clk) begin
        #1;
        if (rst) begin
            sst = 0;
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            s_axis_tvalid = 1'b0;
        end else begin
            case (sst)
                0: if (aw_hs) sst = 1;
                1: if (wl_hs) sst = 2;
                default: if (b_hs) begin sst = 0; s_burst_idx++; end
            endcase
            m_axi_awready = (sst == 0) && (!rnd_en || $urandom_range(0, 1) == 1);
            m_axi_wready  = (sst == 1) && (!rnd_en || $urandom_range(0, 1) == 1);
            if (sst == 2) begin
                if (!m_axi_bvalid) m_axi_bvalid = !rnd_en || $urandom_range(0, 1) == 1;
                m_axi_bresp = (s_burst_idx == err_burst) ? 2'b10 : 2'b00;
            end else begin
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
            end
            if (w_hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() == 0) s_axis_tvalid = 1'b0;
            else if (!(s_axis_tvalid && !w_hs)) s_axis_tvalid = !rnd_en || $urandom_range(0, 1) == 1;
            if (src_q.size() > 0) s_axis_tdata = src_q[0];
        end
    end

    // Reference burst split, pushed to the scoreboard alongside the stream words
    task automatic plan(input logic [15:0] addr, input int len, input logic [31:0] base);
        int a;
        int rem;
        int n;
        int page;
        a = int'(addr) & 32'hFFFC;
        rem = len;
        while (rem > 0) begin
            page = (4096 - (a % 4096)) / 4;
            n = rem;
            if (n > MBL) n = MBL;
            if (n > page) n = page;
            exp_aw_addr.push_back(16'(a));
            exp_aw_len.push_back(8'(n - 1));
            a = (a + n * 4) % 65536;
            rem -= n;
        end
        for (int i = 0; i < len; i++) begin
            src_q.push_back(base + 32'(i));
            exp_w.push_back(base + 32'(i));
        end
    endtask

    task automatic pulse_start(input logic [15:0] addr, input int len);
        @(posedge clk);
        #1;
        cfg_addr  = addr;
        cfg_len   = 16'(len);
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input logic [15:0] addr, input int len,
                            input logic [31:0] base, input logic exp_err,
                            output int cyc_o, output int busy_hi_o);
        int cyc;
        int busy_lo;
        int busy_hi;
        int d0;
        bit got;
        cyc = 0; busy_lo = 0; busy_hi = 0; got = 0;
        plan(addr, len, base);
        d0 = done_cnt;
        pulse_start(addr, len);
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
            else if (!busy) busy_lo++;
            else busy_hi++;
        end
        check_eq({tag, " done seen"}, 64'(got), 64'd1);
        check_eq({tag, " busy held"}, 64'(busy_lo), 64'd0);
        check_eq({tag, " busy at done"}, 64'(busy), 64'd0);
        check_eq({tag, " error"}, 64'(error), 64'(exp_err));
        repeat (3) @(negedge clk);
        check_eq({tag, " done once"}, 64'(done_cnt - d0), 64'd1);
        check_eq({tag, " aw drained"}, 64'(exp_aw_addr.size()), 64'd0);
        check_eq({tag, " w drained"}, 64'(exp_w.size()), 64'd0);
        cyc_o = cyc;
        busy_hi_o = busy_hi;
    endtask

    initial begin
        int cyc;
        int bh;
        int aw0;
        int b0;
        int d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset outputs", 64'({busy, done, error, m_axi_awvalid, m_axi_wvalid,
                                       s_axis_tready, m_axi_bready}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_xfer("single", 16'h0000, 5, 32'h11, 1'b0, cyc, bh);
        for (int i = 0; i < 5; i++) check_eq("ram readback", 64'(mem[i]), 64'(32'h11 + 32'(i)));

        run_xfer("three bursts", 16'h0100, 40, 32'h1000, 1'b0, cyc, bh);
        run_xfer("page split", 16'h0FF2, 8, 32'h2000, 1'b0, cyc, bh);

        rnd_en = 1;
        run_xfer("random", 16'h0804, 33, 32'h3000, 1'b0, cyc, bh);
        rnd_en = 0;

        err_burst = s_burst_idx + 1;
        run_xfer("bresp err", 16'h0400, 20, 32'h4000, 1'b1, cyc, bh);
        err_burst = -1;
        repeat (4) @(negedge clk);
        check_eq("error sticky", 64'(error), 64'd1);

        aw0 = aw_cnt;
        run_xfer("len zero", 16'h0500, 0, 32'h0, 1'b0, cyc, bh);
        check_eq("len0 done latency", 64'(cyc), 64'd2);
        check_eq("len0 busy cycles", 64'(bh), 64'd1);
        check_eq("len0 no aw", 64'(aw_cnt - aw0), 64'd0);

        plan(16'h0200, 8, 32'h5000);
        b0 = beat_total;
        d0 = done_cnt;
        pulse_start(16'h0200, 8);
        cyc = 0;
        while (beat_total - b0 < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("beats before reset", 64'(beat_total - b0), 64'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        src_q.delete();
        exp_w.delete();
        exp_aw_addr.delete();
        exp_aw_len.delete();
        @(negedge clk);
        check_eq("abort outputs", 64'({m_axi_awvalid, m_axi_wvalid, s_axis_tready, busy, done}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("no done after abort", 64'(done_cnt - d0), 64'd0);

        run_xfer("after reset", 16'h0300, 4, 32'h6000, 1'b0, cyc, bh);
        check_eq("w never before aw", 64'(order_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
